// File: rtl/xtor_pkg.sv
// Shared widths, FSM state type and defaults for the transaction initiator.
package xtor_pkg;

    localparam int DATA_W          = 32;
    localparam int TX_W            = 16;
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        RSP  = 2'd3
    } xtor_state_e;

    // A well-behaved core answers with the payload incremented by one.
    function automatic logic rsp_mismatch(input logic [DATA_W-1:0] sent,
                                          input logic [DATA_W-1:0] got);
        return got != (sent + DATA_W'(1));
    endfunction

endpackage

// File: rtl/xtor_fifo.sv
// Request FIFO: power-of-two depth, wrapping pointers, occupancy counter 0..DEPTH.
module xtor_fifo
    import xtor_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DATA_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/xtor_initiator.sv
// Single-outstanding transaction initiator: FIFO-buffered requests, core
// valid/ready handshake with timeout, one-cycle response capture and hold.
module xtor_initiator
    import xtor_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_data,
    output logic              valid,
    input  logic              ready,
    output logic [DATA_W-1:0] data_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              err_timeout,
    output logic [TX_W-1:0]   tx_count
);

    localparam int TW = $clog2(TIMEOUT + 1);

    xtor_state_e       state;
    logic              rdy_en;
    logic [TW-1:0]     stall_cnt;
    logic [TX_W-1:0]   tx_cnt;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;

    // rdy_en keeps req_ready low until the first edge after reset releases.
    assign req_ready = reset && rdy_en && !fifo_full;
    assign fifo_push = req_valid && req_ready;
    assign fifo_pop  = (state == IDLE) && !fifo_empty;
    assign tx_count  = tx_cnt;

    xtor_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (req_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // data_o doubles as the hold register for the in-flight payload.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            rdy_en      <= 1'b0;
            valid       <= 1'b0;
            data_o      <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            err_timeout <= 1'b0;
            tx_cnt      <= '0;
            stall_cnt   <= '0;
        end else begin
            rdy_en <= 1'b1;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        data_o    <= fifo_rdata;
                        valid     <= 1'b1;
                        stall_cnt <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (ready) begin
                        valid  <= 1'b0;
                        tx_cnt <= tx_cnt + TX_W'(1);
                        state  <= WAIT;
                    end else if (stall_cnt == TW'(TIMEOUT - 1)) begin
                        valid       <= 1'b0;
                        err_timeout <= 1'b1;
                        stall_cnt   <= '0;
                        state       <= IDLE;
                    end else begin
                        stall_cnt <= stall_cnt + TW'(1);
                    end
                end
                WAIT: begin
                    rsp_data  <= data_i;
                    rsp_err   <= rsp_mismatch(data_o, data_i);
                    rsp_valid <= 1'b1;
                    state     <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xtor_initiator.sv
// Bench for xtor_initiator: queue-based transaction model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_xtor_initiator;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        ready = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [31:0] req_data = '0;
    logic [31:0] data_i = '0;
    logic        req_ready;
    logic        valid;
    logic [31:0] data_o;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        err_timeout;
    logic [15:0] tx_count;

    xtor_initiator #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .valid       (valid),
        .ready       (ready),
        .data_o      (data_o),
        .data_i      (data_i),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .err_timeout (err_timeout),
        .tx_count    (tx_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: request queue plus the phase of the one live word.
    logic [31:0] m_q[$];
    bit          m_en = 0;
    bit          m_off = 0;
    bit          m_cap = 0;
    bit          m_rsp = 0;
    int          m_stall = 0;
    logic [31:0] m_payload = '0;
    bit          m_valid = 0;
    logic [31:0] m_data_o = '0;
    logic [31:0] m_rsp_data = '0;
    bit          m_rsp_err = 0;
    bit          m_err_to = 0;
    logic [15:0] m_tx = '0;
    bit          started = 0;

    bit          auto_data = 0;
    int          err_pct = 0;
    logic [31:0] got_q[$];

    function automatic bit m_req_ready();
        return reset && m_en && (m_q.size() < DEPTH);
    endfunction

    function automatic bit m_busy();
        return m_off || m_cap || m_rsp || (m_q.size() != 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin : model
        bit acc;
        acc = req_valid && m_req_ready();
        started = 1;
        if (!reset) begin
            m_q.delete();
            m_en = 0; m_off = 0; m_cap = 0; m_rsp = 0; m_stall = 0;
            m_valid = 0; m_data_o = '0; m_rsp_data = '0; m_rsp_err = 0;
            m_err_to = 0; m_tx = '0;
        end else begin
            m_en = 1;
            if (m_off) begin
                if (ready) begin
                    m_off = 0; m_cap = 1; m_valid = 0; m_tx = m_tx + 16'd1;
                end else begin
                    m_stall++;
                    if (m_stall == TIMEOUT) begin
                        m_off = 0; m_valid = 0; m_err_to = 1;
                    end
                end
            end else if (m_cap) begin
                m_cap = 0; m_rsp = 1;
                m_rsp_data = data_i;
                m_rsp_err = (data_i != m_payload + 32'd1);
            end else if (m_rsp) begin
                if (rsp_ready) m_rsp = 0;
            end else if (m_q.size() > 0) begin
                m_payload = m_q.pop_front();
                m_off = 1; m_valid = 1; m_data_o = m_payload; m_stall = 0;
            end
            if (acc) m_q.push_back(req_data);
        end
    end

    always @(negedge clock) begin
        if (started) begin
            chk("req_ready", 32'(req_ready), 32'(m_req_ready()));
            chk("valid", 32'(valid), 32'(m_valid));
            chk("data_o", data_o, m_data_o);
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
            chk("rsp_data", rsp_data, m_rsp_data);
            chk("rsp_err", 32'(rsp_err), 32'(m_rsp_err));
            chk("err_timeout", 32'(err_timeout), 32'(m_err_to));
            chk("tx_count", 32'(tx_count), 32'(m_tx));
            if (rsp_valid && rsp_ready) got_q.push_back(rsp_data);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
        if (auto_data) begin
            if ($urandom_range(0, 99) < err_pct) data_i = $urandom;
            else data_i = m_payload + 32'd1;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (m_busy() && n < 300) begin
            cyc();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_drain actual=busy expected=idle", name);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [31:0] exp_q[$];

        // Reset and reset state
        reset = 1'b0;
        repeat (3) begin
            cyc();
            chk("rst_req_ready", 32'(req_ready), 32'd0);
        end
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_tx", 32'(tx_count), 32'd0);
        chk("rst_err_to", 32'(err_timeout), 32'd0);
        reset = 1'b1;
        cyc();
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);

        // Single transaction at minimum latency
        req_valid = 1; req_data = 32'h10; ready = 1; data_i = 32'h11; rsp_ready = 0;
        cyc();
        req_valid = 0;
        cyc();
        chk("e1_valid", 32'(valid), 32'd1);
        chk("e1_data_o", data_o, 32'h10);
        cyc();
        chk("e2_valid", 32'(valid), 32'd0);
        chk("e2_tx", 32'(tx_count), 32'd1);
        chk("e2_rsp_valid", 32'(rsp_valid), 32'd0);
        cyc();
        chk("e3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("e3_rsp_data", rsp_data, 32'h11);
        chk("e3_rsp_err", 32'(rsp_err), 32'd0);

        // Fill the FIFO while the response is held
        ready = 0;
        for (int i = 1; i <= 4; i++) begin
            req_valid = 1; req_data = 32'(i);
            cyc();
        end
        chk("full_req_ready", 32'(req_ready), 32'd0);
        req_data = 32'd5;
        cyc();
        cyc();
        chk("stall_req_ready", 32'(req_ready), 32'd0);
        chk("fifo_count", 32'(dut.u_fifo.count), 32'd4);
        req_valid = 0;
        got_q.delete();
        ready = 1; rsp_ready = 1; err_pct = 0; auto_data = 1;
        drain("fill");
        exp_q = '{32'h11, 32'd2, 32'd3, 32'd4, 32'd5};
        chk("order_size", 32'(got_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_q.size()) chk("order_rsp", got_q[i], exp_q[i]);
        end

        // Error response held while the consumer stalls
        auto_data = 0; rsp_ready = 0; ready = 1; data_i = 32'hDEAD0000;
        req_valid = 1; req_data = 32'h5;
        cyc();
        req_valid = 0;
        repeat (3) cyc();
        chk("err_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("err_rsp_data", rsp_data, 32'hDEAD0000);
        chk("err_rsp_err", 32'(rsp_err), 32'd1);
        repeat (3) begin
            data_i = $urandom;
            cyc();
            chk("hold_rsp_data", rsp_data, 32'hDEAD0000);
            chk("hold_rsp_err", 32'(rsp_err), 32'd1);
        end
        rsp_ready = 1;
        cyc();
        rsp_ready = 0;
        chk("err_rsp_done", 32'(rsp_valid), 32'd0);

        // Timeout after TIMEOUT stalled cycles, next word still sent
        ready = 0;
        req_valid = 1; req_data = 32'hA0;
        cyc();
        req_data = 32'hB0;
        cyc();
        req_valid = 0;
        chk("to_first_valid", 32'(valid), 32'd1);
        chk("to_first_data", data_o, 32'hA0);
        repeat (TIMEOUT - 1) begin
            cyc();
            chk("to_hold_valid", 32'(valid), 32'd1);
        end
        cyc();
        chk("to_drop_valid", 32'(valid), 32'd0);
        chk("to_flag", 32'(err_timeout), 32'd1);
        cyc();
        chk("to_next_valid", 32'(valid), 32'd1);
        chk("to_next_data", data_o, 32'hB0);
        ready = 1; rsp_ready = 1; err_pct = 0; auto_data = 1;
        drain("timeout");
        chk("to_sticky", 32'(err_timeout), 32'd1);

        // Reset in the middle of SEND
        ready = 0; rsp_ready = 0;
        req_valid = 1; req_data = 32'hC0;
        cyc();
        req_data = 32'hD0;
        cyc();
        req_valid = 0;
        cyc();
        chk("mid_send_valid", 32'(valid), 32'd1);
        reset = 0;
        cyc();
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_tx", 32'(tx_count), 32'd0);
        chk("mid_rst_empty", 32'(dut.u_fifo.empty), 32'd1);
        chk("mid_rst_err_to", 32'(err_timeout), 32'd0);
        reset = 1; ready = 1; rsp_ready = 1;
        repeat (6) begin
            cyc();
            chk("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
        end

        // tx_count wrap via preload
        force dut.tx_cnt = 16'hFFFE;
        m_tx = 16'hFFFE;
        cyc();
        release dut.tx_cnt;
        cyc();
        chk("preload_tx", 32'(tx_count), 32'h0000FFFE);
        req_valid = 1; req_data = 32'h100;
        cyc();
        req_data = 32'h200;
        cyc();
        req_valid = 0;
        drain("wrap");
        chk("wrap_tx", 32'(tx_count), 32'h00000000);

        // Randomized traffic with stall bursts that provoke timeouts
        err_pct = 25;
        for (int i = 0; i < 600; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_data  = $urandom;
            if ((i % 150) < 12) ready = 0;
            else ready = ($urandom_range(0, 9) != 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end
        req_valid = 0; ready = 1; rsp_ready = 1;
        drain("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xtor_initiator.md
XTOR_INITIATOR -- requirements
Module: xtor_initiator

Interface
REQ-001 Parameter DEPTH SHALL default to 4 and set the request FIFO entry count (power of two, 2..16).
REQ-002 Parameter TIMEOUT SHALL default to 255 and set the maximum number of SEND cycles without ready.
REQ-003 Port clock SHALL be an input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit: synchronous, active-low reset.
REQ-005 Port req_valid SHALL be an input, 1 bit: a request word is offered.
REQ-006 Port req_ready SHALL be an output, 1 bit: the FIFO can accept a request.
REQ-007 Port req_data SHALL be an input, 32 bits: the request payload.
REQ-008 Port valid SHALL be an output, 1 bit: the word to the core is valid.
REQ-009 Port ready SHALL be an input, 1 bit: the core is ready.
REQ-010 Port data_o SHALL be an output, 32 bits: the payload to the core.
REQ-011 Port data_i SHALL be an input, 32 bits: the core result.
REQ-012 Port rsp_valid SHALL be an output, 1 bit: a captured response is available.
REQ-013 Port rsp_ready SHALL be an input, 1 bit: the consumer accepts the response.
REQ-014 Port rsp_data SHALL be an output, 32 bits: the captured data_i.
REQ-015 Port rsp_err SHALL be an output, 1 bit, valid with rsp_valid: rsp_data != sent payload + 1 (mod 2^32).
REQ-016 Port err_timeout SHALL be an output, 1 bit: sticky timeout flag.
REQ-017 Port tx_count SHALL be an output, 16 bits: number of completed core handshakes.

Function
REQ-018 A request SHALL be accepted on any edge where req_valid && req_ready; req_ready SHALL equal !full, with no bypass.
REQ-019 The FSM SHALL have four states: IDLE, SEND, WAIT, RSP.
REQ-020 In IDLE with the FIFO non-empty, the FSM SHALL pop the head into a hold register, drive valid=1 and data_o=hold from the next cycle, and go to SEND.
REQ-021 In SEND, valid SHALL stay 1 and data_o SHALL stay stable until an edge with ready=1; on that edge the FSM SHALL go to WAIT, drop valid, and increment tx_count (wraps at 0xFFFF to 0).
REQ-022 In WAIT (exactly one cycle), the FSM SHALL capture data_i into rsp_data, compute rsp_err, and go to RSP.
REQ-023 In RSP, rsp_valid SHALL be 1 and rsp_data/rsp_err SHALL be held until rsp_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-024 Minimum latency SHALL be: push at edge E0, valid high after E1, handshake at E2, rsp_valid high after E3.
REQ-025 In SEND, a cycle counter SHALL count cycles with ready=0; on reaching TIMEOUT it SHALL drop valid, set err_timeout, discard the word, and go to IDLE with no response and no tx_count increment.
REQ-026 A FIFO push SHALL be accepted while the FSM pops in the same cycle; pointers SHALL wrap modulo DEPTH and the occupancy counter SHALL stay in 0..DEPTH.
REQ-027 Only one transaction SHALL be outstanding; the next pop SHALL occur only in IDLE.

Reset
REQ-028 With reset=0 at an edge, the block SHALL empty the FIFO, enter IDLE, and clear valid, data_o, rsp_valid, rsp_data, rsp_err, err_timeout, tx_count and the timeout counter to 0.
REQ-029 req_ready SHALL be 0 during reset and 1 from the first edge after reset=1.
REQ-030 A reset asserted mid-transaction SHALL abandon that transaction with no response.
REQ-031 err_timeout SHALL be cleared only by reset.

Structure
REQ-032 Package xtor_pkg SHALL hold DATA_W=32, the FSM state enum xtor_state_e, and the default TIMEOUT.
REQ-033 The request FIFO SHALL be the sub-module xtor_fifo, parameterised by DEPTH and width.

Verification
REQ-034 The bench SHALL cover: push 0x00000010 with ready=1 -> data_o=0x10 handshake; core returns 0x11 -> rsp_data=0x11, rsp_err=0, tx_count=1, rsp_valid on cycle E3.
REQ-035 The bench SHALL cover: push 5 words with ready=0 and no pop -> req_ready=0 after the 4th accept and the 5th stalls; release -> in-order responses 1..4.
REQ-036 The bench SHALL cover: ready held 0 with TIMEOUT=8 -> valid drops after 8 cycles, err_timeout=1, next FIFO word is sent.
REQ-037 The bench SHALL cover: core returns 0xDEAD0000 for payload 0x5 -> rsp_err=1; rsp_ready=0 for 3 cycles -> rsp_data held stable.
REQ-038 The bench SHALL cover: reset=0 during SEND -> valid=0, FIFO empty and tx_count=0 next cycle, and no rsp_valid afterwards.
REQ-039 The bench SHALL cover: 0x10000 transactions, or tx_count preloaded via force -> tx_count wraps 0xFFFF -> 0x0000.
